// File: rtl/simplez_pkg.sv
//------------------------------------------------------------------------------
// Module  : simplez_pkg
// Brief   : Simplez opcode and sequencer state encodings.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package simplez_pkg;

    localparam int         c_OPW       = 3;

    localparam logic [2:0] c_op_st     = 3'd0;
    localparam logic [2:0] c_op_ld     = 3'd1;
    localparam logic [2:0] c_op_add    = 3'd2;
    localparam logic [2:0] c_op_br     = 3'd3;
    localparam logic [2:0] c_op_bz     = 3'd4;
    localparam logic [2:0] c_op_clr    = 3'd5;
    localparam logic [2:0] c_op_dec    = 3'd6;
    localparam logic [2:0] c_op_halt   = 3'd7;

    localparam logic [1:0] c_s_fetch   = 2'd0;
    localparam logic [1:0] c_s_decode  = 2'd1;
    localparam logic [1:0] c_s_oper    = 2'd2;
    localparam logic [1:0] c_s_halted  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/simplez_alu.sv
//------------------------------------------------------------------------------
// Module  : simplez_alu
// Brief   : Combinational accumulator ALU (LD pass, ADD, DEC, CLR) + zero flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simplez_alu
    import simplez_pkg::*;
#(
    parameter int DATAW = 12
) (
    input  logic [c_OPW-1:0] i_op,
    input  logic [DATAW-1:0] i_ac,
    input  logic [DATAW-1:0] i_opnd,
    output logic [DATAW-1:0] o_result,
    output logic             o_zero
);

    localparam logic [DATAW-1:0] c_one = {{(DATAW-1){1'b0}}, 1'b1};

    always_comb begin
        o_result = i_ac;
        case (i_op)
            c_op_ld:  o_result = i_opnd;
            c_op_add: o_result = i_ac + i_opnd;
            c_op_dec: o_result = i_ac - c_one;
            c_op_clr: o_result = '0;
            default:  o_result = i_ac;
        endcase
    end

    assign o_zero = (i_ac == '0);

endmodule

`default_nettype wire

// File: rtl/simplez_core.sv
//------------------------------------------------------------------------------
// Module  : simplez_core
// Brief   : Simplez CPU core, 8-instruction ISA, req/ack memory bus.
//           Optional single-step gating with macro SIMPLEZ_STEP_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simplez_core
    import simplez_pkg::*;
#(
    parameter int               DATAW = 12,
    parameter int               ADDRW = 9,
    parameter logic [ADDRW-1:0] RSTPC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DATAW-1:0] mem_wdata,
    input  logic [DATAW-1:0] mem_rdata,
    input  logic             mem_ack,
    input  logic             step,
    output logic             stop,
    output logic [ADDRW-1:0] pc_dbg,
    output logic [DATAW-1:0] ac_dbg
);

    generate
        if (DATAW - ADDRW != c_OPW) begin : g_bad_width
            $error("simplez_core: DATAW-ADDRW must equal 3");
        end
    endgenerate

    localparam logic [ADDRW-1:0] c_cp_one = {{(ADDRW-1){1'b0}}, 1'b1};

    logic [1:0]       r_state, w_state_nxt;
    logic [ADDRW-1:0] r_cp, w_cp_nxt;
    logic [DATAW-1:0] r_ri, w_ri_nxt;
    logic [DATAW-1:0] r_ac, w_ac_nxt;

    logic [c_OPW-1:0] w_co;
    logic [ADDRW-1:0] w_cd;
    logic [DATAW-1:0] w_alu_res;
    logic             w_ac_zero;
    logic             w_xfer;
    logic             w_fetch_go;

    assign w_co = r_ri[DATAW-1:ADDRW];
    assign w_cd = r_ri[ADDRW-1:0];

    simplez_alu #(
        .DATAW    (DATAW)
    ) u_alu (
        .i_op     (w_co),
        .i_ac     (r_ac),
        .i_opnd   (mem_rdata),
        .o_result (w_alu_res),
        .o_zero   (w_ac_zero)
    );

`ifdef SIMPLEZ_STEP_EN
    // One captured pulse releases exactly one fetch; pulses outside an idle FETCH are dropped.
    logic r_step_armed;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_step_armed <= 1'b0;
        end else if (r_state == c_s_fetch) begin
            if (w_xfer) begin
                r_step_armed <= 1'b0;
            end else if (step) begin
                r_step_armed <= 1'b1;
            end
        end
    end

    assign w_fetch_go = r_step_armed;
`else
    logic w_unused_step;
    assign w_unused_step = step;
    assign w_fetch_go    = 1'b1;
`endif

    // Request is gated by rst so an in-flight transfer is abandoned immediately.
    assign mem_req   = !rst && (((r_state == c_s_fetch) && w_fetch_go) || (r_state == c_s_oper));
    assign mem_we    = (r_state == c_s_oper) && (w_co == c_op_st);
    assign mem_addr  = (r_state == c_s_oper) ? w_cd : r_cp;
    assign mem_wdata = r_ac;
    assign w_xfer    = mem_req && mem_ack;

    assign stop      = (r_state == c_s_halted);
    assign pc_dbg    = r_cp;
    assign ac_dbg    = r_ac;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state <= c_s_fetch;
            r_cp    <= RSTPC;
            r_ri    <= '0;
            r_ac    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cp    <= w_cp_nxt;
            r_ri    <= w_ri_nxt;
            r_ac    <= w_ac_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cp_nxt    = r_cp;
        w_ri_nxt    = r_ri;
        w_ac_nxt    = r_ac;
        case (r_state)
            c_s_fetch: begin
                if (w_xfer) begin
                    w_ri_nxt    = mem_rdata;
                    w_cp_nxt    = r_cp + c_cp_one;
                    w_state_nxt = c_s_decode;
                end
            end
            c_s_decode: begin
                case (w_co)
                    c_op_st, c_op_ld, c_op_add: begin
                        w_state_nxt = c_s_oper;
                    end
                    c_op_br: begin
                        w_cp_nxt    = w_cd;
                        w_state_nxt = c_s_fetch;
                    end
                    c_op_bz: begin
                        if (w_ac_zero) begin
                            w_cp_nxt = w_cd;
                        end
                        w_state_nxt = c_s_fetch;
                    end
                    c_op_clr, c_op_dec: begin
                        w_ac_nxt    = w_alu_res;
                        w_state_nxt = c_s_fetch;
                    end
                    default: begin
                        w_state_nxt = c_s_halted;
                    end
                endcase
            end
            c_s_oper: begin
                if (w_xfer) begin
                    if ((w_co == c_op_ld) || (w_co == c_op_add)) begin
                        w_ac_nxt = w_alu_res;
                    end
                    w_state_nxt = c_s_fetch;
                end
            end
            default: begin
                w_state_nxt = c_s_halted;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_simplez_core.sv
//------------------------------------------------------------------------------
// Module  : tb_simplez_core
// Brief   : Directed self-checking bench for simplez_core (zero/wait-state RAM).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_simplez_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack, stop, step;
    logic [8:0]  mem_addr, pc_dbg;
    logic [11:0] mem_wdata, mem_rdata, ac_dbg;

    logic [11:0] mem [512];
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    logic        nak = 1'b0;

    int          wr_cnt = 0;
    logic [8:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;

    int          stab_cnt = 0, stab_err = 0;
    logic        hold_prev = 1'b0, p_we = 1'b0;
    logic [8:0]  p_addr = '0;
    logic [11:0] p_wdata = '0;

    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    simplez_core u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .step      (step),
        .stop      (stop),
        .pc_dbg    (pc_dbg),
        .ac_dbg    (ac_dbg)
    );

    // Memory model: combinational read, ack after wait_cfg request cycles.
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && !nak && (wait_cnt >= wait_cfg);

    always @(negedge clk) begin
        if (rst || !mem_req || mem_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
        if (rst) begin
            wr_cnt <= 0;
        end else if (mem_req && mem_ack && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    // Bus signals must hold while a request waits for its ack.
    always @(posedge clk) begin
        #1;
        if (hold_prev && mem_req) begin
            stab_cnt++;
            if (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata))
                stab_err++;
        end
        hold_prev = mem_req && !mem_ack;
        p_addr    = mem_addr;
        p_we      = mem_we;
        p_wdata   = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 12'hE00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b1;
        nak = 1'b0;
        cyc(2);
        check("rst_pc", pc_dbg, 9'd0);
        check("rst_ac", ac_dbg, 12'd0);
        check("rst_req", mem_req, 1'b0);
        check("rst_stop", stop, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_stop(input int max, output int n);
        n = 0;
        while (stop !== 1'b1 && n < max) begin
            @(posedge clk);
            n++;
        end
    endtask

    task automatic load_sum();
        clear_mem();
        mem[0]   = 12'h264;  // LD 100
        mem[1]   = 12'h465;  // ADD 101
        mem[2]   = 12'h066;  // ST 102
        mem[3]   = 12'hE00;  // HALT
        mem[100] = 12'd5;
        mem[101] = 12'd7;
    endtask

    initial begin
        int n;
        step = 1'b0;
        clear_mem();
        fork
            begin
                #200000;
                $display("FAIL timeout: observed=running expected=finished");
                $fatal(1, "timeout");
            end
        join_none

`ifdef SIMPLEZ_STEP_EN
        for (int i = 0; i < 4; i++) mem[i] = 12'hC00;  // DEC
        do_reset();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (mem_req) n++;
        end
        check("nostep_req", n, 0);
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            cyc(6);
        end
        check("step_pc", pc_dbg, 9'd3);
        check("step_ac", ac_dbg, 12'hFFD);
        check("step_stop", stop, 1'b0);
`else
        // Test 1: zero-wait sum
        load_sum();
        wait_cfg = 0;
        do_reset();
        run_stop(200, n);
        check("t1_cycles", n, 11);
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_wr_addr", wr_addr, 9'd102);
        check("t1_wr_data", wr_data, 12'd12);
        check("t1_ac", ac_dbg, 12'd12);
        check("t1_pc", pc_dbg, 9'd4);

        // Test 2: three wait states on every transfer
        load_sum();
        wait_cfg = 3;
        do_reset();
        run_stop(200, n);
        check("t2_cycles", n, 32);
        check("t2_wr_addr", wr_addr, 9'd102);
        check("t2_wr_data", wr_data, 12'd12);
        check("t2_ac", ac_dbg, 12'd12);
        check("t2_stable_seen", stab_cnt > 0, 1'b1);

        // Test 3: CLR; DEC; BZ 50; BR 20 -> CLR; BZ 50 -> HALT @50
        clear_mem();
        mem[0]  = 12'hA00;
        mem[1]  = 12'hC00;
        mem[2]  = 12'h832;
        mem[3]  = 12'h614;
        mem[20] = 12'hA00;
        mem[21] = 12'h832;
        wait_cfg = 0;
        do_reset();
        cyc(4);
        check("t3_dec_ac", ac_dbg, 12'hFFF);
        cyc(2);
        check("t3_bz_nt_pc", pc_dbg, 9'd3);
        cyc(2);
        check("t3_br_pc", pc_dbg, 9'd20);
        check("t3_br_addr", mem_addr, 9'd20);
        check("t3_br_req", mem_req, 1'b1);
        cyc(4);
        check("t3_clr_ac", ac_dbg, 12'd0);
        check("t3_bz_addr", mem_addr, 9'd50);
        check("t3_bz_req", mem_req, 1'b1);
        run_stop(20, n);
        check("t3_halt_cyc", n, 2);
        check("t3_halt_pc", pc_dbg, 9'd51);

        // Test 4: CP wrap after fetch @511, ADD overflow to zero
        clear_mem();
        mem[0]   = 12'h265;  // LD 101
        mem[1]   = 12'h7FF;  // BR 511
        mem[511] = 12'h464;  // ADD 100
        mem[100] = 12'd1;
        mem[101] = 12'hFFF;
        do_reset();
        cyc(3);
        check("t4_ld_ac", ac_dbg, 12'hFFF);
        cyc(3);
        check("t4_wrap_pc", pc_dbg, 9'd0);
        cyc(2);
        check("t4_add_ac", ac_dbg, 12'd0);
        check("t4_fetch_addr", mem_addr, 9'd0);
        check("t4_fetch_req", mem_req, 1'b1);

        // Test 5: reset during a stalled OPER
        clear_mem();
        mem[0]   = 12'h265;  // LD 101
        mem[1]   = 12'h264;  // LD 100
        mem[101] = 12'h123;
        do_reset();
        cyc(4);
        nak = 1'b1;
        cyc(1);
        check("t5_oper_req", mem_req, 1'b1);
        check("t5_oper_addr", mem_addr, 9'd100);
        check("t5_oper_we", mem_we, 1'b0);
        check("t5_ac", ac_dbg, 12'h123);
        cyc(1);
        check("t5_wait_req", mem_req, 1'b1);
        rst = 1'b1;
        cyc(1);
        check("t5_rst_req", mem_req, 1'b0);
        check("t5_rst_pc", pc_dbg, 9'd0);
        check("t5_rst_ac", ac_dbg, 12'd0);
        rst = 1'b0;
        nak = 1'b0;
        #1;
        check("t5_refetch_req", mem_req, 1'b1);
        check("t5_refetch_addr", mem_addr, 9'd0);
        cyc(1);
        check("t5_refetch_pc", pc_dbg, 9'd1);

        check("bus_stable", stab_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
